fetch_ctrl: RTL and testbench

//  Fetch-stage PC register and instruction-bus sequencer. Holds the architectural fetch PC,

---
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch PC register and single-outstanding instruction-bus sequencer feeding decode.
// data_ok in cycle N gives f_valid in N+1; stall holds f_* and parks data in a skid buffer; redirect flushes.
module fetch_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_next,
  input  logic        redirect,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic [63:0] pcplus4,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_misalign
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DISCARD
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        misalign;
    logic [63:0] pc;
    logic [31:0] instr;
  } f_entry_t;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  f_entry_t    f_q, f_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign pcplus4    = pc_q + 64'd4;
  assign ireq_addr  = req_addr_q;
  assign ireq_valid = !reset &&
                      (((state_q == S_REQ) && !misaligned) || (state_q == S_DISCARD));

  assign f_valid    = f_q.valid;
  assign f_misalign = f_q.misalign;
  assign f_pc       = f_q.pc;
  assign f_instr    = f_q.instr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    f_d         = f_q;
    // Flush beats stall; a plain stall keeps every output field frozen.
    if (redirect || !stall) begin
      f_d.valid = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (misaligned) begin
          // No bus request; the fault is re-reported every unstalled cycle until redirected.
          if (redirect) begin
            pc_d       = pc_next;
            req_addr_d = pc_next;
          end else if (!stall) begin
            f_d = '{valid: 1'b1, misalign: 1'b1, pc: pc_q, instr: 32'h0};
          end
        end else if (iresp_data_ok) begin
          if (redirect) begin
            pc_d       = pc_next;
            req_addr_d = pc_next;
          end else if (!stall) begin
            f_d        = '{valid: 1'b1, misalign: 1'b0, pc: pc_q, instr: iresp_data};
            pc_d       = pc_next;
            req_addr_d = pc_next;
          end else begin
            buf_instr_d = iresp_data;
            state_d     = S_HOLD;
          end
        end else if (redirect) begin
          // Request cannot be withdrawn: wait out its response with the old address.
          pc_d    = pc_next;
          state_d = S_DISCARD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d       = pc_next;
          req_addr_d = pc_next;
          state_d    = S_REQ;
        end else if (!stall) begin
          f_d        = '{valid: 1'b1, misalign: 1'b0, pc: pc_q, instr: buf_instr_q};
          pc_d       = pc_next;
          req_addr_d = pc_next;
          state_d    = S_REQ;
        end
      end

      S_DISCARD: begin
        if (redirect) begin
          pc_d = pc_next;
        end
        if (iresp_data_ok) begin
          req_addr_d = redirect ? pc_next : pc_q;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= PC_RESET;
      req_addr_q  <= PC_RESET;
      buf_instr_q <= 32'h0;
      f_q         <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      f_q         <= f_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory responder with variable latency, program-order scoreboard,
// bus-protocol and flush/hold checks, directed scenarios followed by a randomized run.
module tb_fetch_ctrl;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        stall;
  logic [63:0] tgt;
  logic [63:0] pc_next;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic [63:0] pcplus4;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        f_misalign;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_pop;
  int          n_checks = 0;
  int          n_errors = 0;
  int          deliveries = 0;
  int          lat_fix = -1;
  logic [63:0] model_pc;
  bit          last_reset = 1'b1;
  bit          last_redirect = 1'b0;
  logic [63:0] last_tgt;

  bit          ea_en, ev_en, ep_en, ef_en, el_en;
  logic [63:0] ea, ep;
  logic        ev, ef_mis;

  fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .pc_next(pc_next),
    .redirect(redirect),
    .stall(stall),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .pcplus4(pcplus4),
    .f_valid(f_valid),
    .f_pc(f_pc),
    .f_instr(f_instr),
    .f_misalign(f_misalign)
  );

  always #5 clk = ~clk;

  // PC selector stand-in: sequential unless a redirect is active.
  assign pc_next = redirect ? tgt : pcplus4;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // Memory: answers each request after 0..3 cycles (0 = same cycle).
  int          lat_cnt = 0;
  bit          inflight = 1'b0;
  always @(posedge clk) begin
    #2;
    iresp_data_ok = 1'b0;
    if (reset) begin
      inflight = 1'b0;
    end else if (ireq_valid) begin
      if (!inflight) begin
        inflight = 1'b1;
        lat_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
      if (lat_cnt == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem_word(ireq_addr);
        inflight      = 1'b0;
      end else begin
        lat_cnt = lat_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  bit          p_reset = 1'b1, p_redirect = 1'b0, p_stall = 1'b0, p_pend = 1'b0;
  logic [63:0] p_addr, p_fpc;
  logic [31:0] p_fi;
  logic        p_fv, p_fm;

  always @(negedge clk) begin
    if (p_reset || p_redirect) begin
      check("flush_f_valid", 64'(f_valid), 64'd0);
    end else if (p_stall) begin
      check("hold_f_valid", 64'(f_valid), 64'(p_fv));
      check("hold_f_pc", f_pc, p_fpc);
      check("hold_f_instr", 64'(f_instr), 64'(p_fi));
      check("hold_f_misalign", 64'(f_misalign), 64'(p_fm));
    end else if (f_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_delivery: got f_pc %h, expected no delivery", f_pc);
      end else begin
        e_pop = exp_q.pop_front();
        deliveries++;
        check("deliver_pc", f_pc, e_pop.pc);
        check("deliver_instr", 64'(f_instr), 64'(e_pop.instr));
        check("deliver_misalign", 64'(f_misalign), 64'(e_pop.mis));
      end
    end
    if (p_pend && !reset) begin
      check("bus_keep_valid", 64'(ireq_valid), 64'd1);
      check("bus_keep_addr", ireq_addr, p_addr);
    end
    if (ea_en) check("dir_ireq_addr", ireq_addr, ea);
    if (ev_en) check("dir_ireq_valid", 64'(ireq_valid), 64'(ev));
    if (ep_en) check("dir_pcplus4", pcplus4, ep);
    if (ef_en) begin
      check("dir_f_valid", 64'(f_valid), 64'd1);
      check("dir_f_misalign", 64'(f_misalign), 64'(ef_mis));
    end
    if (el_en) begin
      n_checks++;
      if (deliveries < 300) begin
        n_errors++;
        $display("FAIL liveness: got %0d deliveries, expected at least 300", deliveries);
      end
    end
    p_reset    = reset;
    p_redirect = redirect;
    p_stall    = stall;
    p_pend     = ireq_valid && !iresp_data_ok && !reset;
    p_addr     = ireq_addr;
    p_fv       = f_valid;
    p_fpc      = f_pc;
    p_fi       = f_instr;
    p_fm       = f_misalign;
  end

  // One cycle of stimulus; expected program-order deliveries are queued ahead of time
  // and discarded whenever the previous cycle flushed the pipe.
  task automatic step(input bit r, input bit rd, input logic [63:0] t, input bit st);
    exp_t e;
    @(posedge clk);
    #1;
    if (last_reset) begin
      exp_q.delete();
      model_pc = PC_RESET;
    end else if (last_redirect) begin
      exp_q.delete();
      model_pc = last_tgt;
    end
    while (exp_q.size() < 3) begin
      e.pc = model_pc;
      if (model_pc[1:0] != 2'b00) begin
        e.instr = 32'h0;
        e.mis   = 1'b1;
      end else begin
        e.instr  = mem_word(model_pc);
        e.mis    = 1'b0;
        model_pc = model_pc + 64'd4;
      end
      exp_q.push_back(e);
    end
    reset         = r;
    redirect      = rd;
    tgt           = t;
    stall         = st;
    last_reset    = r;
    last_redirect = rd;
    last_tgt      = t;
    ea_en = 1'b0; ev_en = 1'b0; ep_en = 1'b0; ef_en = 1'b0; el_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; stall = 1'b0; tgt = 64'h0;
    ea_en = 1'b0; ev_en = 1'b0; ep_en = 1'b0; ef_en = 1'b0; el_en = 1'b0;
    ea = 64'h0; ep = 64'h0; ev = 1'b0; ef_mis = 1'b0;

    step(1'b1, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0;
    step(1'b1, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0;
    lat_fix = 0;

    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 64'h0, 1'b0);
      ea_en = 1'b1; ea = PC_RESET + 64'(4 * k); ev_en = 1'b1; ev = 1'b1;
      ep_en = (k == 0); ep = PC_RESET + 64'd4;
    end

    // Stall at 0x80000008 for three cycles.
    step(1'b0, 1'b0, 64'h0, 1'b1); ea_en = 1'b1; ea = 64'h8000_0008; ev_en = 1'b1; ev = 1'b1;
    step(1'b0, 1'b0, 64'h0, 1'b1); ev_en = 1'b1; ev = 1'b0;
    step(1'b0, 1'b0, 64'h0, 1'b1); ev_en = 1'b1; ev = 1'b0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_000C; ev_en = 1'b1; ev = 1'b1;

    // Slow request to 0x80000010, redirected while pending.
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_0010; ev_en = 1'b1; ev = 1'b1;
    lat_fix = 3;
    step(1'b0, 1'b1, 64'h8000_2000, 1'b0); ea_en = 1'b1; ea = 64'h8000_0010;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_0010; ev_en = 1'b1; ev = 1'b1;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_0010; ev_en = 1'b1; ev = 1'b1;
    lat_fix = 0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_2000; ev_en = 1'b1; ev = 1'b1;

    // Redirect coinciding with data_ok.
    step(1'b0, 1'b1, 64'h8000_3000, 1'b0); ea_en = 1'b1; ea = 64'h8000_2004;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_3000; ev_en = 1'b1; ev = 1'b1;

    // Redirect beats stall on a live output.
    step(1'b0, 1'b1, 64'h8000_4000, 1'b1); ef_en = 1'b1; ef_mis = 1'b0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h8000_4000; ev_en = 1'b1; ev = 1'b1;

    // Misaligned target: fault entry, no bus traffic.
    step(1'b0, 1'b1, 64'h8000_0002, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0; ef_en = 1'b1; ef_mis = 1'b1;
    step(1'b0, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0;

    // pcplus4 wraps at 2^64.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    ea_en = 1'b1; ea = 64'hFFFF_FFFF_FFFF_FFFC; ev_en = 1'b1; ev = 1'b1; ep_en = 1'b1; ep = 64'h0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = 64'h0; ev_en = 1'b1; ev = 1'b1;

    // Reset while discarding.
    lat_fix = 3;
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b1, 64'h8000_6000, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0); ev_en = 1'b1; ev = 1'b0;
    step(1'b0, 1'b0, 64'h0, 1'b0); ea_en = 1'b1; ea = PC_RESET; ev_en = 1'b1; ev = 1'b1;
    lat_fix = -1;

    for (int i = 0; i < 3000; i++) begin
      bit          r, rd, st;
      logic [63:0] t;
      r  = ($urandom_range(0, 499) == 0);
      rd = !r && ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 3) == 0);
      t  = {32'h0, 32'h8000_0000 | ($urandom_range(0, 1023) << 2)};
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step(r, rd, t, st);
    end

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
    el_en = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
